// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: operating-mode encoding and the
// stage-count helper used by the pipelined adders.
package arith_pkg;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   function automatic int calc_nblk(input int width, input int blk);
      return width / blk;
   endfunction

endpackage

// File: rtl/cba_block.sv
// Combinational BLK-bit carry-bypass slice: block sum, group propagate,
// bypassed carry out and the carry into the slice's top bit.
module cba_block #(
   parameter int BLK = 8
) (
   input  logic [BLK-1:0] a,
   input  logic [BLK-1:0] b,
   input  logic           c,
   output logic [BLK-1:0] s,
   output logic           p,
   output logic           c_out,
   output logic           c_msb
);

   logic [BLK:0] sum_ext;

   assign sum_ext = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, c};
   assign s       = sum_ext[BLK-1:0];
   assign p       = &(a ^ b);
   // When every bit propagates, the incoming carry skips the ripple chain.
   assign c_out   = p ? c : sum_ext[BLK];
   assign c_msb   = s[BLK-1] ^ a[BLK-1] ^ b[BLK-1];

endmodule

// File: rtl/cba_pipe.sv
// Pipelined carry-bypass adder/subtractor: one BLK-bit bypass block per stage,
// valid/ready handshake with whole-pipe stall.
module cba_pipe
   import arith_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int BLK   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int NBLK = calc_nblk(WIDTH, BLK);

   if (WIDTH % BLK != 0) begin : g_bad_width
      $fatal(1, "cba_pipe: WIDTH must be a multiple of BLK");
   end

   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             c0;

   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;
   assign b_eff    = (sub == MODE_ADD) ? b : ~b;
   assign c0       = (sub == MODE_SUB) ? 1'b1 : cin;

   for (genvar k = 0; k < NBLK; k++) begin : g_stage
      localparam int RW = WIDTH - BLK * k;   // operand bits still to be added
      localparam int SW = BLK * (k + 1);     // sum bits completed after this stage

      logic [RW-1:0]  a_k, b_k;
      logic           c_k, v_k;
      logic [BLK-1:0] blk_s;
      logic           blk_p, blk_c, blk_msb;
      logic [SW-1:0]  s_k;
      logic [SW-1:0]  s_q;
      logic           c_q, v_q;
      logic           p_unused;

      if (k == 0) begin : g_head
         assign a_k = a;
         assign b_k = b_eff;
         assign c_k = c0;
         assign v_k = in_valid;
         assign s_k = blk_s;
      end else begin : g_link
         assign a_k = g_stage[k-1].g_fwd.a_q;
         assign b_k = g_stage[k-1].g_fwd.b_q;
         assign c_k = g_stage[k-1].c_q;
         assign v_k = g_stage[k-1].v_q;
         assign s_k = {blk_s, g_stage[k-1].s_q};
      end

      cba_block #(.BLK(BLK)) u_blk (
         .a     (a_k[BLK-1:0]),
         .b     (b_k[BLK-1:0]),
         .c     (c_k),
         .s     (blk_s),
         .p     (blk_p),
         .c_out (blk_c),
         .c_msb (blk_msb)
      );

      // Group propagate is already folded into blk_c inside the block.
      assign p_unused = blk_p;

      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples its predecessor's pre-edge value.
      always_ff @(posedge clk or posedge rst) begin
         if (rst)      v_q <= 1'b0;
         else if (adv) v_q <= v_k;
      end

      if (k < NBLK - 1) begin : g_fwd
         logic [RW-BLK-1:0] a_q, b_q;
         logic              msb_unused;

         assign msb_unused = blk_msb;

         // NOTE: interior datapath registers are deliberately not reset; the
         // valid bits alone decide whether their contents mean anything.
         always_ff @(posedge clk) begin
            if (adv) begin
               a_q <= a_k[RW-1:BLK];
               b_q <= b_k[RW-1:BLK];
               s_q <= s_k;
               c_q <= blk_c;
            end
         end
      end else begin : g_tail
         logic o_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s_q <= '0;
               c_q <= 1'b0;
               o_q <= 1'b0;
            end else if (adv) begin
               s_q <= s_k;
               c_q <= blk_c;
               o_q <= blk_msb ^ blk_c;
            end
         end

         assign s         = s_q;
         assign cout      = c_q;
         assign ovf       = o_q;
         assign out_valid = v_q;
      end
   end

endmodule

// File: tb/tb_cba_pipe.sv
// Scoreboard bench for cba_pipe: directed corner vectors, back-pressure,
// async reset flush and a random stream with random downstream stalls.
module tb_cba_pipe;

   localparam int WIDTH = 32;
   localparam int BLK   = 8;
   localparam int NBLK  = WIDTH / BLK;

   typedef struct {
      logic [WIDTH-1:0] s;
      logic             cout;
      logic             ovf;
      int               t0;
      int               st0;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             cin = 1'b0;
   logic             sub = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;

   exp_t             sb[$];
   int               n_vec = 0;
   int               n_err = 0;
   int               cyc = 0;
   int               stall_cnt = 0;
   logic             prev_stall = 1'b0;
   logic [WIDTH-1:0] prev_s = '0;

   cba_pipe #(.WIDTH(WIDTH), .BLK(BLK)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                  input logic ic, input logic isub);
      exp_t             e;
      logic [WIDTH-1:0] bb;
      logic [WIDTH:0]   full;
      bb     = isub ? ~ib : ib;
      full   = {1'b0, ia} + {1'b0, bb} + (WIDTH+1)'(isub ? 1'b1 : ic);
      e.s    = full[WIDTH-1:0];
      e.cout = full[WIDTH];
      e.ovf  = (ia[WIDTH-1] == bb[WIDTH-1]) && (e.s[WIDTH-1] != ia[WIDTH-1]);
      e.t0   = 0;
      e.st0  = 0;
      return e;
   endfunction

   // One clock: drive inputs, score the handshakes that happen on the next edge.
   task automatic step(input logic iv, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                       input logic ic, input logic isub, input logic ordy, output logic acc);
      exp_t e;
      exp_t x;
      @(negedge clk);
      in_valid  = iv;
      a         = ia;
      b         = ib;
      cin       = ic;
      sub       = isub;
      out_ready = ordy;
      #1;
      if (prev_stall) begin
         check("hold_s", 64'(s), 64'(prev_s));
         check("hold_valid", 64'(out_valid), 64'd1);
      end
      check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
         check("pop_nonempty", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            x = sb.pop_front();
            check("s", 64'(s), 64'(x.s));
            check("cout", 64'(cout), 64'(x.cout));
            check("ovf", 64'(ovf), 64'(x.ovf));
            check("latency", 64'(cyc - x.t0), 64'(NBLK + stall_cnt - x.st0));
         end
      end
      acc = iv && in_ready;
      if (acc) begin
         e     = model(ia, ib, ic, isub);
         e.t0  = cyc;
         e.st0 = stall_cnt;
         sb.push_back(e);
      end
      prev_stall = out_valid && !out_ready;
      prev_s     = s;
      if (prev_stall) stall_cnt++;
      cyc++;
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
   endtask

   initial begin
      logic             acc;
      logic [WIDTH-1:0] va [8];
      logic [WIDTH-1:0] vb [8];
      logic [WIDTH-1:0] ra, rb;
      int               k;

      #12;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_s", 64'(s), 64'd0);
      check("rst_cout", 64'(cout), 64'd0);
      check("rst_ovf", 64'(ovf), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // Directed corner vectors at full rate.
      step(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, acc);
      step(1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 1'b1, acc);
      step(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, acc);
      step(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b1, acc);
      step(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, acc);
      idle(NBLK + 2);

      // Back-pressure: 8 beats, downstream stalled for stream cycles 5..9.
      for (int i = 0; i < 8; i++) begin
         va[i] = $urandom();
         vb[i] = $urandom();
      end
      k = 0;
      for (int i = 0; i < 40 && k < 8; i++) begin
         step(1'b1, va[k], vb[k], i[0], i[1], !(i >= 5 && i <= 9), acc);
         if (acc) k++;
      end
      check("bp_all_accepted", 64'(k), 64'd8);
      idle(NBLK + 6);
      check("bp_drained", 64'(sb.size()), 64'd0);

      // Async reset with beats in flight and a stalled output.
      for (int i = 0; i < NBLK + 1; i++) step(i < NBLK, $urandom(), $urandom(), 1'b0, 1'b0, 1'b0, acc);
      check("pre_rst_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_out_valid", 64'(out_valid), 64'd0);
      check("async_s", 64'(s), 64'd0);
      check("async_in_ready", 64'(in_ready), 64'd1);
      sb.delete();
      prev_stall = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      step(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b1, acc);
      idle(NBLK + 3);
      check("post_rst_drained", 64'(sb.size()), 64'd0);

      // Random stream with random downstream readiness and operand corners.
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 5))
            0:       ra = '1;
            1:       ra = {1'b1, {(WIDTH-1){1'b0}}};
            default: ra = $urandom();
         endcase
         case ($urandom_range(0, 5))
            0:       rb = ~ra;
            1:       rb = '0;
            default: rb = $urandom();
         endcase
         step($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, acc);
      end
      for (int i = 0; i < 50 && sb.size() != 0; i++) idle(1);
      check("final_drained", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cba_pipe.md
Name: cba_pipe

Overview:
Parametrised, pipelined carry-bypass adder/subtractor. It is the successor to the fixed 32-bit combinational carry-bypass adder in the arithmetic library. Operands are split into BLK-bit blocks, and each block is one pipeline stage with its own group-propagate bypass on the carry. A valid/ready handshake with full-pipe stall lets it sit between streaming datapath stages.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of BLK.
BLK, 8, bits per bypass block and per pipeline stage.
NBLK, WIDTH/BLK, derived (localparam); number of stages, i.e. latency.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept operand beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry in; ignored when sub=1
sub  input  1  1: s = a - b (b inverted, carry in forced 1); 0: s = a + b + cin
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
s  output  WIDTH  sum/difference
cout  output  1  carry out of MSB (for sub: 1 = no borrow)
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (async, rst=1): all stage valid bits 0; s, cout, ovf 0; out_valid 0. in_ready = 1 immediately after reset.
- Pipe advance: adv = ~out_valid | out_ready; in_ready = adv. When adv=0, every stage register (data and valid) holds. Bubbles are not collapsed while stalled.
- Accept: a beat enters stage 0 when in_valid & in_ready. An unaccepted beat is not captured. Inputs may change freely while in_ready=0.
- Operand prep at entry: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage k (0..NBLK-1) computes block k:
  - p = a_k ^ b_eff_k; P_k = &p.
  - {cr_k, s_k} = a_k + b_eff_k + c_k.
  - c_(k+1) = P_k ? c_k : cr_k.
  - It registers s_k, c_(k+1), its valid bit, and the still-unused upper operand slices; upper slices are shifted forward skewed.
  - Completed lower sum slices are carried forward so the full s appears aligned at the last stage.
- Latency: exactly NBLK cycles from accept to out_valid with no stalls (4 at defaults). Throughput is 1 beat/cycle.
- cout = c_NBLK. ovf uses the carry into bit WIDTH-1, taken from the final block's internal add.
- Outputs s/cout/ovf are registered at the final stage and are stable while out_valid & ~out_ready.
- Simultaneous: output retire and input accept in the same cycle are legal and required. Full-rate stream with out_ready=1 never drops in_ready.
- rst mid-operation: all in-flight beats are discarded; out_valid = 0 in the same cycle (async).
- NBLK=1 is legal: a single registered stage with latency 1.
- Elaboration check: WIDTH % BLK != 0 is a fatal elaboration error.

Decomposition:
- Shared package arith_pkg: function to compute NBLK; the add/sub mode encoding constant (MODE_ADD=0, MODE_SUB=1).
- One natural sub-module: cba_block, the combinational BLK-bit slice (inputs a, b, c; outputs s, group propagate, bypassed carry, carry into MSB).
- cba_pipe instantiates NBLK cba_block slices in a generate loop, each followed by its stage register.

Test Plan:
- Defaults, a=0xFFFF_FFFF, b=0x0000_0001, cin=0, sub=0 -> after 4 cycles: s=0x0000_0000, cout=1, ovf=0.
- Full-bypass path, a=0xAAAA_AAAA, b=0x5555_5555, cin=1 (every block P=1) -> s=0x0000_0000, cout=1, ovf=0.
- Subtract, a=0x8000_0000, b=0x0000_0001, sub=1 -> s=0x7FFF_FFFF, cout=1, ovf=1. Also a=5, b=7 -> s=0xFFFF_FFFE, cout=0, ovf=0.
- Back-pressure: stream 8 beats, hold out_ready=0 for cycles 5-9 -> in_ready=0 during the stall, out_valid held, s stable; all 8 results delivered in order with no loss or duplication.
- Async reset asserted with 3 beats in flight -> out_valid drops in the same cycle. After release, a new beat gives a correct result NBLK cycles later and no stale beat appears.
- Parameter sweep WIDTH=16/BLK=4 and WIDTH=8/BLK=8: 10k random a/b/cin/sub with random out_ready -> every result matches the reference model a±b; latency equals NBLK when unstalled.
